rx_code_correlator: RTL and testbench
=====================================

Name: rx_code_correlator

Overview:
- Receive-side counterpart of the transmit code generator.
- Takes baseband ADC samples after downconversion and integrates them over each chip (t_b samples per chip, integrate-and-dump).
- Correlates the chip stream against the same binary phase code (codigo, num_dig) that the transmitter sends.
- Emits one pulse-compressed range bin per chip period, starting at each sinc pulse. Sits between the receive downconverter and the range/Doppler buffer.

Parameters:
DATA_W, 14, signed input sample width
TB_W, 16, width of the chip-length field taken from i_tb
MAX_DIG, 32, maximum code length (shift-register depth)
CORR_W, DATA_W+TB_W+6 (=36), signed correlation output width

Ports:
i_clk  in  1  system clock (adc_clk domain)
i_rst  in  1  synchronous reset, active-low
i_sinc  in  1  PRT sync from sinc_generator; rising edge starts a frame
i_data  in  DATA_W  signed baseband sample
i_valid  in  1  i_data qualifier
i_codigo  in  32  code word; bit 1 = +1, bit 0 = -1
i_numdig  in  32  code length; bits [5:0] used, legal 1..MAX_DIG
i_tb  in  32  samples per chip; bits [TB_W-1:0] used, legal >=1
i_nbins  in  16  range bins per frame, legal >=1
o_corr  out  CORR_W  signed correlation value
o_valid  out  1  o_corr/o_bin strobe, one cycle
o_bin  out  16  range bin index of o_corr, 0-based
o_busy  out  1  frame in progress
o_err  out  1  sticky: illegal configuration at last sinc edge

Behaviour:
- Reset: i_rst low at a clock edge clears all state. o_corr=0, o_valid=0, o_bin=0, o_busy=0, o_err=0, state IDLE. Accumulator, shift register and counters are zeroed.
- Edge detect: i_sinc is registered once; edge = i_sinc & ~sinc_q.
- Config latch: on an edge, i_codigo, i_numdig[5:0], i_tb[TB_W-1:0] and i_nbins are latched. Later changes to the inputs have no effect until the next edge.
- Illegal config: if numdig==0, numdig>MAX_DIG, tb==0 or nbins==0, then o_err<=1, state stays IDLE and no outputs are produced. A legal edge clears o_err.
- States: IDLE, INTEG.
  - IDLE -> INTEG on a legal edge. Accumulator, sample counter, chip counter, bin counter and shift register are cleared; o_busy<=1.
  - INTEG -> IDLE on the cycle the bin with index nbins-1 is issued to the pipeline; o_busy<=0 that cycle.
- Sample capture: the first sample counted is the first i_valid sample after the edge cycle; the edge-cycle sample is ignored. Cycles with i_valid low are ignored.
- Integrate-and-dump:
  - Each valid sample is added to a signed accumulator of DATA_W+TB_W bits (sign-extended, no saturation).
  - On the tb-th sample, chip = acc + sample is shifted into sr[0] (sr[k] moves to sr[k+1]) and acc is cleared that same cycle.
- Code mapping: c_k = i_codigo[numdig-1-k], where k=0 is the first transmitted chip (MSB-first, matching the transmitter).
- Correlation: corr = sum over k=0..numdig-1 of c_k * sr[numdig-1-k]. Entries sr[j] with j>=numdig do not contribute.
- Output timing:
  - Bins are produced only once numdig chips have been shifted in. The dump of chip numdig-1 yields bin 0; each later dump yields the next bin.
  - Pipeline: stage 1 applies the sign flip and forms 4 partial sums of 8 terms; stage 2 forms the final sum. o_valid is asserted exactly 2 cycles after the dump cycle, with o_bin = bin index.
- Sign flip: multiplication by -1 is two's-complement negation in CORR_W bits; no overflow is possible at max parameters.
- Edge while in INTEG: the frame aborts and restarts immediately (same as a legal edge from IDLE). Pipeline outputs still in flight from the aborted frame are suppressed (o_valid kept 0), and o_bin restarts at 0.
- Edge coinciding with a dump: the edge wins; that chip is discarded.
- Synchronous reset mid-frame: frame discarded, no o_valid on the following cycles.

Decomposition:
- Package rx_pkg holds DATA_W, TB_W, MAX_DIG, CORR_W, the state enum {IDLE, INTEG} and a function for the CORR_W width.
- Sub-module chip_integrator (accumulator + sample counter, dump strobe and chip value out).
- The correlation shift register, code mapping and adder pipeline stay in the top module.

Test Plan:
- Matched code: tb=4, numdig=3, codigo=6 (+1,+1,-1), nbins=4. Continuous valid after the edge: samples +100 x4, +100 x4, -100 x4, then 0. Required: o_corr = 1200, 0, -400, 0 for bins 0..3; bin 0 o_valid at cycle 14 after the edge cycle; o_busy falls after bin 3.
- Gapped valid: same stimulus with i_valid low every other cycle. Same o_corr values; bin 0 o_valid at cycle 26 after the edge (24 cycles to the chip-2 dump, +2 pipeline).
- Illegal config: numdig=0, or numdig=33, or tb=0. Required: o_err=1, o_busy=0, no o_valid. A following legal edge clears o_err.
- Restart: a second sinc edge arrives in INTEG 1 cycle before bin 1 would be issued. No bin-1 output from the old frame; the new frame's bin 0 appears at cycle 14 after the second edge.
- Max length: numdig=32, codigo=0xFFFFFFFF, tb=1, samples constant +8191 (max positive). Bin 0 o_corr = 262112 (32 x 8191); the next bins stay 262112 while the input stays constant.
- Reset mid-frame: i_rst low for 1 cycle during INTEG. All outputs 0 on the next cycle; no o_valid until a new sinc edge.

Source files
------------

// File: rtl/rx_pkg.sv
// rx_pkg: shared widths, state type and width helper for the receive code correlator
package rx_pkg;
  localparam int DATA_W = 14;
  localparam int TB_W = 16;
  localparam int MAX_DIG = 32;
  localparam int ACC_W = DATA_W + TB_W;
  function automatic int corr_width(input int dw, input int tw);
    return dw + tw + 6;
  endfunction
  localparam int CORR_W = corr_width(DATA_W, TB_W);
  typedef enum logic {IDLE, INTEG} state_e;
endpackage

// File: rtl/chip_integrator.sv
// chip_integrator: integrate-and-dump of tb valid samples into one chip value
module chip_integrator
  import rx_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic                    i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic [TB_W-1:0]         i_tb,
  output logic                    o_dump,
  output logic signed [ACC_W-1:0] o_chip
);
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [TB_W-1:0] cnt_q, cnt_d;
  logic take;
  always_comb begin
    take = i_en & i_valid;
    o_chip = acc_q + {{TB_W{i_data[DATA_W-1]}}, i_data};
    o_dump = take && cnt_q + TB_W'(1) == i_tb;
    acc_d = i_clr ? '0 : !take ? acc_q : o_dump ? '0 : o_chip;
    cnt_d = i_clr ? '0 : !take ? cnt_q : o_dump ? '0 : cnt_q + TB_W'(1);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rx_code_correlator.sv
// rx_code_correlator: chip integration plus sliding correlation against the transmit phase code
module rx_code_correlator
  import rx_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_sinc,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_valid,
  input  logic [31:0]              i_codigo,
  input  logic [31:0]              i_numdig,
  input  logic [31:0]              i_tb,
  input  logic [15:0]              i_nbins,
  output logic signed [CORR_W-1:0] o_corr,
  output logic                     o_valid,
  output logic [15:0]              o_bin,
  output logic                     o_busy,
  output logic                     o_err
);
  state_e state_q, state_d;
  logic sinc_q, sinc_edge, en, dump, dump_bin, last, cfg_bad, unused_cfg;
  logic signed [ACC_W-1:0] chip;
  logic [31:0] code_q, code_d;
  logic [5:0] numdig_q, numdig_d, chips_q, chips_d;
  logic [TB_W-1:0] tb_q, tb_d;
  logic [15:0] nbins_q, nbins_d, bin_q, bin_d, ibin_q, ibin_d, b1_q, b1_d, obin_q, obin_d;
  logic [MAX_DIG-1:0][ACC_W-1:0] sr_q, sr_d;
  logic [MAX_DIG-1:0][CORR_W-1:0] term;
  logic [3:0][CORR_W-1:0] p_q, p_d;
  logic [CORR_W-1:0] corr_q, corr_d;
  logic issue_q, issue_d, v1_q, v1_d, valid_q, valid_d, err_q, err_d;

  assign unused_cfg = ^{i_numdig[31:6], i_tb[31:TB_W]};
  assign sinc_edge = i_sinc & ~sinc_q;
  assign en = state_q == INTEG && !sinc_edge;

  chip_integrator u_integ (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (sinc_edge),
    .i_en   (en),
    .i_valid(i_valid),
    .i_data (i_data),
    .i_tb   (tb_q),
    .o_dump (dump),
    .o_chip (chip)
  );

  // sr[j] pairs with codigo[j]; slots at or beyond numdig drop out of the sum
  for (genvar g = 0; g < MAX_DIG; g++) begin : g_term
    logic [CORR_W-1:0] ext;
    assign ext = {{(CORR_W-ACC_W){sr_q[g][ACC_W-1]}}, sr_q[g]};
    assign term[g] = 6'(g) >= numdig_q ? '0 : code_q[g] ? ext : -ext;
  end

  for (genvar g = 0; g < 4; g++) begin : g_part
    assign p_d[g] = term[8*g] + term[8*g+1] + term[8*g+2] + term[8*g+3]
                  + term[8*g+4] + term[8*g+5] + term[8*g+6] + term[8*g+7];
  end

  always_comb begin
    cfg_bad = i_numdig[5:0] == 6'd0 || i_numdig[5:0] > 6'(MAX_DIG) || i_tb[TB_W-1:0] == '0 || i_nbins == 16'd0;
    dump_bin = dump && chips_q + 6'd1 >= numdig_q;
    last = dump_bin && bin_q == nbins_q - 16'd1;
    state_d = sinc_edge ? (cfg_bad ? IDLE : INTEG) : last ? IDLE : state_q;
    err_d = sinc_edge ? cfg_bad : err_q;
    code_d = sinc_edge ? i_codigo : code_q;
    numdig_d = sinc_edge ? i_numdig[5:0] : numdig_q;
    tb_d = sinc_edge ? i_tb[TB_W-1:0] : tb_q;
    nbins_d = sinc_edge ? i_nbins : nbins_q;
    chips_d = sinc_edge ? '0 : dump && chips_q < numdig_q ? chips_q + 6'd1 : chips_q;
    bin_d = sinc_edge ? '0 : dump_bin ? bin_q + 16'd1 : bin_q;
    sr_d = sinc_edge ? '0 : dump ? {sr_q[MAX_DIG-2:0], chip} : sr_q;
    issue_d = dump_bin;
    ibin_d = bin_q;
    // a new edge kills anything still travelling down the adder pipeline
    v1_d = issue_q && !sinc_edge;
    b1_d = ibin_q;
    valid_d = v1_q && !sinc_edge;
    corr_d = valid_d ? p_q[0] + p_q[1] + p_q[2] + p_q[3] : corr_q;
    obin_d = valid_d ? b1_q : obin_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      sinc_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= '0;
      numdig_q <= '0;
      tb_q <= '0;
      nbins_q <= '0;
      chips_q <= '0;
      bin_q <= '0;
      sr_q <= '0;
      issue_q <= 1'b0;
      ibin_q <= '0;
      p_q <= '0;
      v1_q <= 1'b0;
      b1_q <= '0;
      valid_q <= 1'b0;
      corr_q <= '0;
      obin_q <= '0;
    end else begin
      state_q <= state_d;
      sinc_q <= i_sinc;
      err_q <= err_d;
      code_q <= code_d;
      numdig_q <= numdig_d;
      tb_q <= tb_d;
      nbins_q <= nbins_d;
      chips_q <= chips_d;
      bin_q <= bin_d;
      sr_q <= sr_d;
      issue_q <= issue_d;
      ibin_q <= ibin_d;
      p_q <= p_d;
      v1_q <= v1_d;
      b1_q <= b1_d;
      valid_q <= valid_d;
      corr_q <= corr_d;
      obin_q <= obin_d;
    end
  end

  assign o_corr = corr_q;
  assign o_valid = valid_q;
  assign o_bin = obin_q;
  assign o_busy = state_q == INTEG;
  assign o_err = err_q;
endmodule

// File: tb/tb_rx_code_correlator.sv
// tb_rx_code_correlator: directed frame vectors plus restart, illegal-config and reset sequences
module tb_rx_code_correlator;
  import rx_pkg::*;
  logic i_clk = 1'b0;
  logic i_rst, i_sinc, i_valid;
  logic signed [DATA_W-1:0] i_data;
  logic [31:0] i_codigo, i_numdig, i_tb;
  logic [15:0] i_nbins;
  logic signed [CORR_W-1:0] o_corr;
  logic o_valid, o_busy, o_err;
  logic [15:0] o_bin;
  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int tb;
    int numdig;
    logic [31:0] code;
    int nbins;
    int gap;
    int n_amp;
    int amp[4];
    int tail;
    int first;
    longint ecorr[4];
  } vec_t;
  vec_t vecs[5];

  always #5 i_clk = ~i_clk;

  rx_code_correlator dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sinc  (i_sinc),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_codigo(i_codigo),
    .i_numdig(i_numdig),
    .i_tb    (i_tb),
    .i_nbins (i_nbins),
    .o_corr  (o_corr),
    .o_valid (o_valid),
    .o_bin   (o_bin),
    .o_busy  (o_busy),
    .o_err   (o_err)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int amp_at(input vec_t v, input int s);
    int idx;
    idx = s / v.tb;
    return idx < v.n_amp ? v.amp[idx] : v.tail;
  endfunction

  task automatic set_cfg(input vec_t v);
    i_codigo = v.code;
    i_numdig = 32'(v.numdig);
    i_tb = 32'(v.tb);
    i_nbins = 16'(v.nbins);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int s, got, first, lim;
    s = 0;
    got = 0;
    first = -1;
    lim = v.first + v.nbins * v.tb * (v.gap != 0 ? 2 : 1) + 4;
    set_cfg(v);
    i_sinc = 1'b1;
    i_valid = 1'b1;
    i_data = DATA_W'(999);
    step();
    chk({tag, "_busy_start"}, longint'(o_busy), 1);
    chk({tag, "_err_start"}, longint'(o_err), 0);
    i_sinc = 1'b0;
    for (int c = 1; c <= lim; c++) begin
      i_valid = !(v.gap != 0 && c % 2 == 1);
      if (i_valid) begin
        i_data = DATA_W'(amp_at(v, s));
        s++;
      end else i_data = DATA_W'(-1234);
      step();
      if (o_valid) begin
        if (first < 0) first = c;
        if (got < 4 && got < v.nbins) begin
          chk($sformatf("%s_corr%0d", tag, got), longint'($signed(o_corr)), v.ecorr[got]);
          chk($sformatf("%s_bin%0d", tag, got), longint'(o_bin), longint'(got));
        end
        got++;
      end
    end
    chk({tag, "_first_cycle"}, longint'(first), longint'(v.first));
    chk({tag, "_bin_count"}, longint'(got), longint'(v.nbins));
    chk({tag, "_busy_end"}, longint'(o_busy), 0);
    chk({tag, "_err_end"}, longint'(o_err), 0);
  endtask

  task automatic illegal(input int nd, input int tbv, input string tag);
    int nv;
    nv = 0;
    i_codigo = 32'd6;
    i_numdig = 32'(nd);
    i_tb = 32'(tbv);
    i_nbins = 16'd4;
    i_sinc = 1'b1;
    i_valid = 1'b1;
    i_data = DATA_W'(100);
    step();
    i_sinc = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (o_valid) nv++;
    end
    chk({tag, "_valid_count"}, longint'(nv), 0);
    chk({tag, "_err"}, longint'(o_err), 1);
    chk({tag, "_busy"}, longint'(o_busy), 0);
  endtask

  // second edge lands at cycle rc of the first frame
  task automatic restart(input int rc, input string tag);
    int s;
    logic ev;
    logic seen;
    s = 0;
    seen = 1'b0;
    set_cfg(vecs[0]);
    i_sinc = 1'b1;
    i_valid = 1'b1;
    i_data = DATA_W'(999);
    step();
    for (int c = 1; c <= rc + 14; c++) begin
      i_sinc = c == rc;
      if (c == rc) begin
        i_data = DATA_W'(999);
        s = 0;
      end else begin
        i_data = DATA_W'(amp_at(vecs[0], s));
        s++;
      end
      step();
      ev = (c == 14 && rc > 14) || c == rc + 14;
      chk($sformatf("%s_valid_c%0d", tag, c), longint'(o_valid), longint'(ev));
      if (ev && o_valid) begin
        chk($sformatf("%s_corr_c%0d", tag, c), longint'($signed(o_corr)), 1200);
        chk($sformatf("%s_bin_c%0d", tag, c), longint'(o_bin), 0);
        if (c == rc + 14) seen = 1'b1;
      end
    end
    i_sinc = 1'b0;
    chk({tag, "_new_bin0"}, longint'(seen), 1);
  endtask

  task automatic reset_mid();
    int nv;
    nv = 0;
    set_cfg(vecs[0]);
    i_sinc = 1'b1;
    i_valid = 1'b1;
    i_data = DATA_W'(999);
    step();
    i_sinc = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      i_data = DATA_W'(amp_at(vecs[0], c - 1));
      step();
    end
    chk("rst_pre_corr", longint'($signed(o_corr)), -400);
    i_rst = 1'b0;
    step();
    i_rst = 1'b1;
    chk("rst_corr", longint'($signed(o_corr)), 0);
    chk("rst_valid", longint'(o_valid), 0);
    chk("rst_bin", longint'(o_bin), 0);
    chk("rst_busy", longint'(o_busy), 0);
    chk("rst_err", longint'(o_err), 0);
    for (int c = 0; c < 30; c++) begin
      i_data = DATA_W'(100);
      step();
      if (o_valid) nv++;
    end
    chk("rst_after_valid_count", longint'(nv), 0);
  endtask

  initial begin
    vecs[0] = '{4, 3, 32'h6, 4, 0, 3, '{100, 100, -100, 0}, 0, 14, '{1200, 0, -400, 0}};
    vecs[1] = '{4, 3, 32'h6, 4, 1, 3, '{100, 100, -100, 0}, 0, 26, '{1200, 0, -400, 0}};
    vecs[2] = '{3, 1, 32'h0, 2, 0, 2, '{7, -5, 0, 0}, 0, 5, '{-21, 15, 0, 0}};
    vecs[3] = '{2, 4, 32'hA, 2, 0, 4, '{50, -50, 50, -50}, 0, 10, '{400, -300, 0, 0}};
    vecs[4] = '{1, 32, 32'hFFFF_FFFF, 3, 0, 0, '{0, 0, 0, 0}, 8191, 34, '{262112, 262112, 262112, 0}};
    i_rst = 1'b0;
    i_sinc = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    i_codigo = '0;
    i_numdig = '0;
    i_tb = '0;
    i_nbins = '0;
    step();
    step();
    chk("reset_corr", longint'($signed(o_corr)), 0);
    chk("reset_valid", longint'(o_valid), 0);
    chk("reset_bin", longint'(o_bin), 0);
    chk("reset_busy", longint'(o_busy), 0);
    chk("reset_err", longint'(o_err), 0);
    i_rst = 1'b1;
    step();
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    illegal(0, 4, "ill_nd0");
    illegal(33, 4, "ill_nd33");
    illegal(3, 0, "ill_tb0");
    run_vec(vecs[2], "after_illegal");
    restart(15, "restart15");
    restart(13, "restart13");
    restart(12, "restart12");
    reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
